// File: rtl/tl45_decode.sv
// TL45 decode stage: splits instruction words into fields and registers one micro-op per cycle.
// Define TL45_DECODE_EXPAND_EN to expand CALL/RET into SW/ADD/JMP micro-op sequences.
module tl45_decode #(
    parameter logic [3:0] SP_REG = 4'd15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    input  logic        i_pipe_flush,
    output logic        o_pipe_stall,
    input  logic [31:0] i_buf_pc,
    input  logic [31:0] i_buf_inst,
    output logic [31:0] o_dr_pc,
    output logic [4:0]  o_dr_opcode,
    output logic [3:0]  o_dr_dr,
    output logic [3:0]  o_dr_sr1,
    output logic [3:0]  o_dr_sr2,
    output logic [31:0] o_dr_imm32,
    output logic        o_dr_imm_valid,
    output logic        o_dr_uflag,
    output logic        o_dr_illegal
);

    typedef struct packed {
        logic [4:0]  opcode;
        logic [3:0]  dr;
        logic [3:0]  sr1;
        logic [3:0]  sr2;
        logic [31:0] imm32;
        logic        imm_valid;
        logic        uflag;
        logic        illegal;
    } uop_t;

    uop_t        dec_uop;
    logic [31:0] dec_pc;
    logic [15:0] imm16;
    uop_t        uop_q, uop_d;
    logic [31:0] pc_q, pc_d;

    always_comb begin
        imm16   = i_buf_inst[15:0];
        dec_uop = '0;
        dec_pc  = '0;
        if (i_buf_inst != 32'h0) begin
            dec_pc            = i_buf_pc;
            dec_uop.opcode    = i_buf_inst[31:27];
            dec_uop.dr        = i_buf_inst[23:20];
            dec_uop.sr1       = i_buf_inst[19:16];
            dec_uop.sr2       = i_buf_inst[15:12];
            dec_uop.imm_valid = i_buf_inst[26];
            dec_uop.illegal   = (i_buf_inst[31:30] == 2'b11);
            if (i_buf_inst[25]) begin
                dec_uop.imm32 = {imm16, 16'h0};
            end else if (i_buf_inst[24]) begin
                dec_uop.imm32 = {16'h0, imm16};
            end else begin
                dec_uop.imm32 = {{16{imm16[15]}}, imm16};
            end
        end
    end

`ifdef TL45_DECODE_EXPAND_EN
    localparam logic [4:0]  OpAdd     = 5'h01;
    localparam logic [4:0]  OpJmp     = 5'h0C;
    localparam logic [4:0]  OpCall    = 5'h0D;
    localparam logic [4:0]  OpRet     = 5'h0E;
    localparam logic [4:0]  OpSw      = 5'h15;
    localparam logic [31:0] PlusFour  = 32'h0000_0004;
    localparam logic [31:0] MinusFour = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {StIdle, StExp1, StExp2} state_e;

    state_e      state_q, state_d;
    uop_t        parent_q, parent_d;
    logic [31:0] ppc_q, ppc_d;

    // Stack micro-op: base register is always the stack pointer, operand is the immediate.
    function automatic uop_t sp_uop(input logic [4:0] op, input logic [3:0] dr,
                                    input logic [31:0] imm, input logic uflag);
        uop_t u;
        u           = '0;
        u.opcode    = op;
        u.dr        = dr;
        u.sr1       = SP_REG;
        u.imm32     = imm;
        u.imm_valid = 1'b1;
        u.uflag     = uflag;
        return u;
    endfunction

    always_comb begin
        state_d  = state_q;
        parent_d = parent_q;
        ppc_d    = ppc_q;
        uop_d    = uop_q;
        pc_d     = pc_q;
        if (i_pipe_flush) begin
            state_d  = StIdle;
            parent_d = '0;
            ppc_d    = '0;
            uop_d    = '0;
            pc_d     = '0;
        end else if (!i_pipe_stall) begin
            unique case (state_q)
                StIdle: begin
                    uop_d = dec_uop;
                    pc_d  = dec_pc;
                    if (dec_uop.opcode == OpCall) begin
                        parent_d = dec_uop;
                        ppc_d    = dec_pc;
                        state_d  = StExp1;
                        uop_d    = sp_uop(OpSw, 4'd0, MinusFour, 1'b1);
                    end else if (dec_uop.opcode == OpRet) begin
                        parent_d = dec_uop;
                        ppc_d    = dec_pc;
                        state_d  = StExp1;
                        uop_d    = sp_uop(OpAdd, SP_REG, PlusFour, 1'b0);
                    end
                end
                StExp1: begin
                    pc_d = ppc_q;
                    if (parent_q.opcode == OpCall) begin
                        uop_d   = sp_uop(OpAdd, SP_REG, MinusFour, 1'b0);
                        state_d = StExp2;
                    end else begin
                        uop_d   = sp_uop(OpJmp, 4'd0, MinusFour, 1'b1);
                        state_d = StIdle;
                    end
                end
                StExp2: begin
                    pc_d         = ppc_q;
                    uop_d        = parent_q;
                    uop_d.opcode = OpJmp;
                    state_d      = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Reset holds the sequencer idle, so fetch sees only the downstream stall.
    assign o_pipe_stall = i_pipe_stall | (!i_reset && (state_d != StIdle));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= StIdle;
            parent_q <= '0;
            ppc_q    <= '0;
        end else begin
            state_q  <= state_d;
            parent_q <= parent_d;
            ppc_q    <= ppc_d;
        end
    end
`else
    always_comb begin
        uop_d = uop_q;
        pc_d  = pc_q;
        if (i_pipe_flush) begin
            uop_d = '0;
            pc_d  = '0;
        end else if (!i_pipe_stall) begin
            uop_d = dec_uop;
            pc_d  = dec_pc;
        end
    end

    assign o_pipe_stall = i_pipe_stall;

    // SP_REG only matters to the expansion sequencer.
    if (SP_REG == 4'd0) begin : g_sp_reg_unused
    end
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            uop_q <= '0;
            pc_q  <= '0;
        end else begin
            uop_q <= uop_d;
            pc_q  <= pc_d;
        end
    end

    assign o_dr_pc        = pc_q;
    assign o_dr_opcode    = uop_q.opcode;
    assign o_dr_dr        = uop_q.dr;
    assign o_dr_sr1       = uop_q.sr1;
    assign o_dr_sr2       = uop_q.sr2;
    assign o_dr_imm32     = uop_q.imm32;
    assign o_dr_imm_valid = uop_q.imm_valid;
    assign o_dr_uflag     = uop_q.uflag;
    assign o_dr_illegal   = uop_q.illegal;

endmodule
